// File: rtl/ring_router_pkg.sv
// Shared ring-router types: flit geometry, VC identifiers, per-VC slot states, hop decrement.
package ring_router_pkg;

   localparam int DATA_WIDTH = 64;
   localparam int HOP_LSB    = 48;
   localparam int HOP_WIDTH  = 8;

   typedef enum logic {
      VC_EVEN = 1'b0,
      VC_ODD  = 1'b1
   } vc_e;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

   // One-hot hop count: each traversed link shifts the marker one place down.
   function automatic logic [DATA_WIDTH-1:0] hop_dec(input logic [DATA_WIDTH-1:0] flit);
      logic [DATA_WIDTH-1:0] res;
      res = flit;
      res[HOP_LSB +: HOP_WIDTH] = flit[HOP_LSB +: HOP_WIDTH] >> 1;
      return res;
   endfunction

endpackage

// File: rtl/vc_rr_slot.sv
// Round-robin arbiter plus one-flit buffer for a single virtual channel.
// ARB_FLOW_THROUGH_EN lets a draining slot accept its next flit in the same cycle.
//   state      | meaning
//   SLOT_EMPTY | buffer free, grants the round-robin winner
//   SLOT_FULL  | holding a flit until its polarity phase and out_ready
module vc_rr_slot
   import ring_router_pkg::*;
#(
   parameter int  NUM_REQ    = 3,
   parameter int  DATA_WIDTH = ring_router_pkg::DATA_WIDTH,
   parameter int  HOP_LSB    = ring_router_pkg::HOP_LSB,
   parameter int  HOP_WIDTH  = ring_router_pkg::HOP_WIDTH,
   parameter vc_e VC         = VC_EVEN
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          polarity_i,
   input  logic [NUM_REQ-1:0]            req_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] data_i,
   input  logic                          out_ready_i,
   output logic [NUM_REQ-1:0]            grant_o,
   output logic                          drain_o,
   output logic [DATA_WIDTH-1:0]         drain_data_o
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   slot_state_e           state_q, state_d;
   logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [DATA_WIDTH-1:0] buf_q, buf_d;
   logic [PTR_W-1:0]      win_idx;
   logic                  found;
   logic                  load_ok;
   logic                  load;
   int                    idx;

   always_comb begin
      found   = 1'b0;
      win_idx = '0;
      idx     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(rr_ptr_q) + k) % NUM_REQ;
         if (!found && req_i[idx]) begin
            found   = 1'b1;
            win_idx = PTR_W'(idx);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      buf_d    = buf_q;
      grant_o  = '0;
      drain_o  = (state_q == SLOT_FULL) && out_ready_i && (polarity_i == 1'(VC));
`ifdef ARB_FLOW_THROUGH_EN
      load_ok  = (state_q == SLOT_EMPTY) || drain_o;
`else
      load_ok  = (state_q == SLOT_EMPTY);
`endif
      // Grant is suppressed during reset so no requester dequeues into a held-clear buffer.
      load     = load_ok && found && rst_n;
      if (drain_o) begin
         state_d = SLOT_EMPTY;
      end
      if (load) begin
         grant_o[win_idx] = 1'b1;
         state_d          = SLOT_FULL;
         buf_d            = data_i[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
         rr_ptr_d         = PTR_W'((int'(win_idx) + 1) % NUM_REQ);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= SLOT_EMPTY;
         rr_ptr_q <= '0;
         buf_q    <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         buf_q    <= buf_d;
      end
   end

   if (DATA_WIDTH == ring_router_pkg::DATA_WIDTH && HOP_LSB == ring_router_pkg::HOP_LSB &&
       HOP_WIDTH == ring_router_pkg::HOP_WIDTH) begin : g_pkg_hop
      assign drain_data_o = hop_dec(buf_q);
   end else begin : g_gen_hop
      always_comb begin
         drain_data_o = buf_q;
         drain_data_o[HOP_LSB +: HOP_WIDTH] = buf_q[HOP_LSB +: HOP_WIDTH] >> 1;
      end
   end

endmodule

// File: rtl/ring_vc_arbiter.sv
// Ring router output-port scheduler: two per-VC slots sharing one registered link output.
// Optional macro ARB_FLOW_THROUGH_EN enables same-cycle drain-and-reload per VC.
module ring_vc_arbiter
   import ring_router_pkg::*;
#(
   parameter int NUM_REQ    = 3,
   parameter int DATA_WIDTH = ring_router_pkg::DATA_WIDTH,
   parameter int HOP_LSB    = ring_router_pkg::HOP_LSB,
   parameter int HOP_WIDTH  = ring_router_pkg::HOP_WIDTH
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          polarity,
   input  logic [NUM_REQ-1:0]            req_even,
   input  logic [NUM_REQ-1:0]            req_odd,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] data_in_even,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] data_in_odd,
   output logic [NUM_REQ-1:0]            grant_even,
   output logic [NUM_REQ-1:0]            grant_odd,
   input  logic                          out_ready,
   output logic                          out_send,
   output logic [DATA_WIDTH-1:0]         out_data
);

   logic                  drain_even, drain_odd;
   logic [DATA_WIDTH-1:0] drain_data_even, drain_data_odd;
   logic                  out_send_q, out_send_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

   vc_rr_slot #(
      .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .HOP_LSB(HOP_LSB),
      .HOP_WIDTH(HOP_WIDTH), .VC(VC_EVEN)
   ) u_slot_even (
      .clk(clk), .rst_n(rst), .polarity_i(polarity), .req_i(req_even),
      .data_i(data_in_even), .out_ready_i(out_ready), .grant_o(grant_even),
      .drain_o(drain_even), .drain_data_o(drain_data_even)
   );

   vc_rr_slot #(
      .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .HOP_LSB(HOP_LSB),
      .HOP_WIDTH(HOP_WIDTH), .VC(VC_ODD)
   ) u_slot_odd (
      .clk(clk), .rst_n(rst), .polarity_i(polarity), .req_i(req_odd),
      .data_i(data_in_odd), .out_ready_i(out_ready), .grant_o(grant_odd),
      .drain_o(drain_odd), .drain_data_o(drain_data_odd)
   );

   // Polarity makes the two drains mutually exclusive, so a simple priority mux suffices.
   always_comb begin
      out_send_d = drain_even || drain_odd;
      out_data_d = out_data_q;
      if (drain_even) begin
         out_data_d = drain_data_even;
      end else if (drain_odd) begin
         out_data_d = drain_data_odd;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_send_q <= 1'b0;
         out_data_q <= '0;
      end else begin
         out_send_q <= out_send_d;
         out_data_q <= out_data_d;
      end
   end

   assign out_send = out_send_q;
   assign out_data = out_data_q;

endmodule
